mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Iterative signed multiply/divide unit for the multicycle datapath, directly downstream of the ALU operand-select stage.
- Consumes the A register and the same B operand the ALU source-B select passes through (select 00).
- Executes MULT and DIV over DATA_W iterations; results go to architectural Hi/Lo registers.
- Controller starts an operation with a one-cycle pulse, stalls on Busy, and advances on Done.

Parameters:
DATA_W, 32, operand width; also the number of iteration cycles.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
Start_Mult  input  1  pulse: begin signed A*B
Start_Div  input  1  pulse: begin signed A/B
A  input  DATA_W  operand A (multiplicand / dividend)
B  input  DATA_W  operand B (multiplier / divisor)
Hi  output  DATA_W  MULT: product[2*DATA_W-1:DATA_W]; DIV: remainder
Lo  output  DATA_W  MULT: product[DATA_W-1:0]; DIV: quotient
Busy  output  1  high while an operation is in progress
Done  output  1  one-cycle pulse when Hi/Lo have just been updated
DivZero  output  1  divide-by-zero flag (see Optional Feature)

Behaviour:
- Reset (synchronous, any state): Hi=0, Lo=0, Busy=0, Done=0, DivZero=0, FSM=IDLE. Aborts any operation in flight; no Done is produced for it.
- FSM states: IDLE, CALC, FIX.
- IDLE: Busy=0.
  - Start_Mult sampled high: capture A and B, store magnitudes and result sign, clear the iteration counter, go to CALC, Busy=1.
  - Start_Div sampled high (Start_Mult low): same capture, in divide mode.
  - Start_Mult and Start_Div both high: MULT executes; Start_Div is ignored.
- CALC: one iteration per clock, DATA_W iterations, counter 0..DATA_W-1; leaves to FIX after the last one.
  - Multiply: unsigned shift-add on the magnitudes into a 2*DATA_W accumulator.
  - Divide: restoring shift-subtract on the magnitudes.
- FIX (one clock): apply signs, write Hi/Lo, Done=1 for this cycle only, Busy=0, return to IDLE.
- Latency: Hi/Lo change and Done rises on the (DATA_W+1)th rising edge after the capture edge (33rd for DATA_W=32). Busy is high for exactly DATA_W+1 cycles.
- Sign rules:
  - Product is negated when sign(A) xor sign(B).
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
- Overflow case: most-negative / -1 gives Lo = most-negative (wraps), Hi = 0. No flag.
- Starts while Busy: ignored, with no effect on the running operation.
- Hi/Lo hold their value between completions. Operand inputs may change after the capture edge without effect.
- Start pulses arriving in the same cycle as Done (FIX) are ignored. The earliest accepted start is the cycle after Done.

Optional Feature:
Macro MULTDIV_DIVZERO_EN.
- Defined:
  - A DIV captured with B==0 skips CALC and goes straight to FIX.
  - Done and DivZero pulse together on the edge after capture (Busy high 1 cycle).
  - Hi/Lo are left unchanged.
  - DivZero is low at all other times.
- Undefined:
  - DivZero is tied 0.
  - Divide by zero runs the full DATA_W+1 cycles with the natural restoring result: magnitude quotient all-ones, remainder |A|, then the normal sign fixup.
  - Example: A=7, B=0 gives Lo=0xFFFFFFFF, Hi=0x00000007.

Test Plan:
- Assert reset for 2 cycles -> Hi=0, Lo=0, Busy=0, Done=0, DivZero=0.
- Start_Mult, A=0xFFFFFFFD (-3), B=5 -> Busy high 33 cycles. Done pulses once on the 33rd edge with Hi=0xFFFFFFFF, Lo=0xFFFFFFF1.
- Start_Mult, A=B=0x7FFFFFFF -> Hi=0x3FFFFFFF, Lo=0x00000001.
- Start_Div, A=0xFFFFFFF9 (-7), B=2 -> Lo=0xFFFFFFFD (-3), Hi=0xFFFFFFFF (-1).
- Start_Div, A=0x80000000, B=0xFFFFFFFF -> Lo=0x80000000, Hi=0x00000000.
- Start_Div, A=7, B=0:
  - Macro defined: Done=DivZero=1 on the edge after capture; Hi/Lo keep their previous values.
  - Macro undefined: Done on the 33rd edge with Lo=0xFFFFFFFF, Hi=7, DivZero=0.
- Start_Mult, then Start_Div pulsed at iteration 5, then reset at iteration 10:
  - The Start_Div pulse is ignored.
  - After reset: Hi=Lo=0, Busy=0, no Done pulse.
  - A new Start_Mult the next cycle completes normally.

Source files
------------

// File: rtl/mult_div_unit_if.sv
// Operand/result bundle for the iterative multiply/divide unit.
// The controller drives the master side; the unit is the slave.
interface mult_div_unit_if #(
  parameter int DATA_W = 32
);
  logic              Start_Mult;
  logic              Start_Div;
  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] B;
  logic [DATA_W-1:0] Hi;
  logic [DATA_W-1:0] Lo;
  logic              Busy;
  logic              Done;
  logic              DivZero;

  modport master (
    output Start_Mult, Start_Div, A, B,
    input  Hi, Lo, Busy, Done, DivZero
  );

  modport slave (
    input  Start_Mult, Start_Div, A, B,
    output Hi, Lo, Busy, Done, DivZero
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative signed MULT/DIV into Hi/Lo over DATA_W cycles.
// Define MULTDIV_DIVZERO_EN to short-circuit divide-by-zero with a flag.
module mult_div_unit #(
  parameter int DATA_W = 32
) (
  input  logic            clk,
  input  logic            reset,
  mult_div_unit_if.slave  bus
);

  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [CW-1:0]       r_cnt;
  logic                r_is_div;
  logic                r_neg_p;
  logic                r_neg_a;
  logic [DATA_W-1:0]   r_mcand;
  logic [2*DATA_W-1:0] r_acc;
  logic [DATA_W-1:0]   r_dvsr;
  logic [DATA_W-1:0]   r_rem;
  logic [DATA_W-1:0]   r_quo;
  logic [DATA_W-1:0]   r_hi;
  logic [DATA_W-1:0]   r_lo;
  logic                r_done;

  logic w_start_m;
  logic w_start_d;
  logic w_load;
  logic w_step;
  logic w_fin;
  logic w_skip;

  // The Done cycle is the last cycle of an operation; starts there are dropped.
  assign w_start_m = bus.Start_Mult & ~r_done;
  assign w_start_d = bus.Start_Div & ~bus.Start_Mult & ~r_done;

`ifdef MULTDIV_DIVZERO_EN
  logic r_zero;
  logic r_dz;
  assign w_skip      = w_start_d & (bus.B == '0);
  assign bus.DivZero = r_dz;
`else
  assign w_skip      = 1'b0;
  assign bus.DivZero = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_step = 1'b0;
    w_fin  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start_m | w_start_d) begin
          w_load = 1'b1;
          w_next = w_skip ? FIX : CALC;
        end
      end
      CALC: begin
        w_step = 1'b1;
        if (r_cnt == LAST) w_next = FIX;
      end
      FIX: begin
        w_fin  = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  logic              w_a_sgn;
  logic              w_b_sgn;
  logic [DATA_W-1:0] w_a_mag;
  logic [DATA_W-1:0] w_b_mag;

  assign w_a_sgn = bus.A[DATA_W-1];
  assign w_b_sgn = bus.B[DATA_W-1];
  assign w_a_mag = w_a_sgn ? (~bus.A + 1'b1) : bus.A;
  assign w_b_mag = w_b_sgn ? (~bus.B + 1'b1) : bus.B;

  // Shift-add: add multiplicand into the high half, then shift right.
  logic [DATA_W:0]     w_sum;
  logic [2*DATA_W-1:0] w_acc_nxt;

  assign w_sum = {1'b0, r_acc[2*DATA_W-1:DATA_W]}
               + {1'b0, (r_acc[0] ? r_mcand : {DATA_W{1'b0}})};
  assign w_acc_nxt = {w_sum, r_acc[DATA_W-1:1]};

  // Restoring divide: dividend bits shift out of r_quo into r_rem.
  logic [DATA_W:0]   w_sh;
  logic              w_ge;
  logic [DATA_W-1:0] w_diff;

  assign w_sh   = {r_rem, r_quo[DATA_W-1]};
  assign w_ge   = (w_sh >= {1'b0, r_dvsr});
  assign w_diff = w_sh[DATA_W-1:0] - r_dvsr;

  logic [2*DATA_W-1:0] w_prod;
  logic [DATA_W-1:0]   w_quo_s;
  logic [DATA_W-1:0]   w_rem_s;

  assign w_prod  = r_neg_p ? (~r_acc + 1'b1) : r_acc;
  assign w_quo_s = r_neg_p ? (~r_quo + 1'b1) : r_quo;
  assign w_rem_s = r_neg_a ? (~r_rem + 1'b1) : r_rem;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg_p  <= 1'b0;
      r_neg_a  <= 1'b0;
      r_mcand  <= '0;
      r_acc    <= '0;
      r_dvsr   <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_load) begin
        r_cnt    <= '0;
        r_is_div <= ~w_start_m;
        r_neg_p  <= w_a_sgn ^ w_b_sgn;
        r_neg_a  <= w_a_sgn;
        r_mcand  <= w_a_mag;
        r_acc    <= {{DATA_W{1'b0}}, w_b_mag};
        r_dvsr   <= w_b_mag;
        r_rem    <= '0;
        r_quo    <= w_a_mag;
      end
      if (w_step) begin
        r_cnt <= r_cnt + 1'b1;
        if (r_is_div) begin
          r_rem <= w_ge ? w_diff : w_sh[DATA_W-1:0];
          r_quo <= {r_quo[DATA_W-2:0], w_ge};
        end else begin
          r_acc <= w_acc_nxt;
        end
      end
      if (w_fin) begin
        r_done <= 1'b1;
`ifdef MULTDIV_DIVZERO_EN
        if (!r_zero) begin
`else
        begin
`endif
          if (r_is_div) begin
            r_hi <= w_rem_s;
            r_lo <= w_quo_s;
          end else begin
            r_hi <= w_prod[2*DATA_W-1:DATA_W];
            r_lo <= w_prod[DATA_W-1:0];
          end
        end
      end
    end
  end

`ifdef MULTDIV_DIVZERO_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      r_zero <= 1'b0;
      r_dz   <= 1'b0;
    end else begin
      r_dz <= w_fin & r_zero;
      if (w_load) r_zero <= w_skip;
    end
  end
`endif

  assign bus.Hi   = r_hi;
  assign bus.Lo   = r_lo;
  assign bus.Busy = (r_state != IDLE);
  assign bus.Done = r_done;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed MULT/DIV vectors,
// latency, divide-by-zero and reset-abort behaviour.
module tb_mult_div_unit;

  localparam int W = 32;

  logic clk;
  logic reset;

  mult_div_unit_if #(.DATA_W(W)) bus ();

  mult_div_unit #(.DATA_W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string nm, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every Done pulse is matched against the scoreboard head.
  always @(negedge clk) begin
    if (bus.Done === 1'b1) begin
      if (q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL done_unexpected: got Done=1 expected none");
      end else begin
        exp_t e;
        e = q.pop_front();
        check("hi", bus.Hi, e.hi);
        check("lo", bus.Lo, e.lo);
        check("divzero", {31'd0, bus.DivZero}, {31'd0, e.dz});
      end
    end else if (bus.DivZero === 1'b1) begin
      n_vec++;
      n_err++;
      $display("FAIL divzero_stray: got 1 expected 0");
    end
  end

  // Called at a negedge; returns at a negedge one cycle after Done.
  task automatic run_op(input string nm, input bit m, input bit d,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] hi, input logic [W-1:0] lo,
                        input bit dz, input int busy_exp);
    exp_t e;
    int   n;
    e.hi = hi;
    e.lo = lo;
    e.dz = dz;
    q.push_back(e);
    bus.Start_Mult = m;
    bus.Start_Div  = d;
    bus.A          = a;
    bus.B          = b;
    @(negedge clk);
    bus.Start_Mult = 1'b0;
    bus.Start_Div  = 1'b0;
    bus.A          = 32'hDEAD_BEEF;
    bus.B          = 32'h1234_5678;
    n = 0;
    while (bus.Busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    check({nm, "_busy_cycles"}, n, busy_exp);
    check({nm, "_done_at_busy_fall"}, {31'd0, bus.Done}, 32'd1);
    @(negedge clk);
  endtask

  initial begin
    reset          = 1'b1;
    bus.Start_Mult = 1'b0;
    bus.Start_Div  = 1'b0;
    bus.A          = '0;
    bus.B          = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_hi", bus.Hi, 32'd0);
    check("rst_lo", bus.Lo, 32'd0);
    check("rst_busy", {31'd0, bus.Busy}, 32'd0);
    check("rst_done", {31'd0, bus.Done}, 32'd0);
    check("rst_dz", {31'd0, bus.DivZero}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op("mul_m3x5", 1, 0, 32'hFFFF_FFFD, 32'd5,
           32'hFFFF_FFFF, 32'hFFFF_FFF1, 0, 33);
    run_op("mul_max2", 1, 0, 32'h7FFF_FFFF, 32'h7FFF_FFFF,
           32'h3FFF_FFFF, 32'h0000_0001, 0, 33);
    run_op("mul_min2", 1, 0, 32'h8000_0000, 32'h8000_0000,
           32'h4000_0000, 32'h0000_0000, 0, 33);
    run_op("mul_both", 1, 1, 32'd6, 32'hFFFF_FFFE,
           32'hFFFF_FFFF, 32'hFFFF_FFF4, 0, 33);
    run_op("div_m7d2", 0, 1, 32'hFFFF_FFF9, 32'd2,
           32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 33);
    run_op("div_7dm2", 0, 1, 32'd7, 32'hFFFF_FFFE,
           32'h0000_0001, 32'hFFFF_FFFD, 0, 33);
    run_op("div_100d7", 0, 1, 32'd100, 32'd7,
           32'd2, 32'd14, 0, 33);
    run_op("div_ovf", 0, 1, 32'h8000_0000, 32'hFFFF_FFFF,
           32'h0000_0000, 32'h8000_0000, 0, 33);
`ifdef MULTDIV_DIVZERO_EN
    run_op("div_zero", 0, 1, 32'd7, 32'd0,
           32'h0000_0000, 32'h8000_0000, 1, 1);
`else
    run_op("div_zero", 0, 1, 32'd7, 32'd0,
           32'h0000_0007, 32'hFFFF_FFFF, 0, 33);
`endif

    // Abort: Start_Div mid-operation ignored, then reset at iteration 10.
    bus.Start_Mult = 1'b1;
    bus.A          = 32'd3;
    bus.B          = 32'd4;
    @(negedge clk);
    bus.Start_Mult = 1'b0;
    repeat (4) @(negedge clk);
    bus.Start_Div = 1'b1;
    bus.B         = 32'd0;
    @(negedge clk);
    bus.Start_Div = 1'b0;
    check("abort_busy_mid", {31'd0, bus.Busy}, 32'd1);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_hi", bus.Hi, 32'd0);
    check("abort_lo", bus.Lo, 32'd0);
    check("abort_busy", {31'd0, bus.Busy}, 32'd0);
    check("abort_done", {31'd0, bus.Done}, 32'd0);
    run_op("mul_after", 1, 0, 32'd12, 32'hFFFF_FFFD,
           32'hFFFF_FFFF, 32'hFFFF_FFDC, 0, 33);

    repeat (3) @(negedge clk);
    check("sb_drain", q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
